// File: rtl/hw2_bist_pkg.sv
// Shared widths, FSM state type, LFSR taps and golden model for the hw2 datapath BIST.
// The optional HW2_BIST_FAIL_CAPTURE_EN build needs nothing from this package beyond these items.
package hw2_bist_pkg;

  localparam int A_W    = 8;
  localparam int D_W    = 16;
  localparam int CNT_W  = 16;
  localparam int LFSR_W = 32;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // 9-bit add/sub (borrow wraps) times c, truncated to the 16-bit datapath result
  function automatic logic [D_W-1:0] hw2_golden(
    input logic [A_W-1:0] a,
    input logic [A_W-1:0] b,
    input logic [A_W-1:0] c,
    input logic           s
  );
    logic [A_W:0] sum9;
    sum9 = s ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    return {{(D_W-A_W-1){1'b0}}, sum9} * {{(D_W-A_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/hw2_bist_lfsr.sv
// 32-bit Galois LFSR for the hw2 BIST; presents the fields of the state it will hold after this edge.
module hw2_bist_lfsr
  import hw2_bist_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              load,
  input  logic              step,
  output logic [A_W-1:0]    a_nxt,
  output logic [A_W-1:0]    b_nxt,
  output logic [A_W-1:0]    c_nxt,
  output logic              s_nxt
);

  logic [LFSR_W-1:0] q;
  logic [LFSR_W-1:0] q_nxt;

  always_comb begin
    q_nxt = load ? seed : ((q >> 1) ^ (q[0] ? LFSR_TAPS : '0));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      q <= seed;
    end else if (load || step) begin
      q <= q_nxt;
    end
  end

  assign a_nxt = q_nxt[7:0];
  assign b_nxt = q_nxt[15:8];
  assign s_nxt = q_nxt[16];
  assign c_nxt = q_nxt[31:24];

endmodule

// File: rtl/hw2_bist_ctrl.sv
// Stimulus generator and response checker for the hw2 datapath d = ((s ? a+b : a-b) * c)[15:0].
// Define HW2_BIST_FAIL_CAPTURE_EN to add first-failure capture outputs fail_idx/fail_exp/fail_act.
module hw2_bist_ctrl
  import hw2_bist_pkg::*;
#(
  parameter int          NUM_VEC = 301,
  parameter int          DUT_LAT = 0,
  parameter logic [31:0] SEED    = 32'h1D87_2B41
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  output logic [A_W-1:0]   a,
  output logic [A_W-1:0]   b,
  output logic [A_W-1:0]   c,
  output logic             s,
  output logic             vec_vld,
  input  logic [D_W-1:0]   d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
`ifdef HW2_BIST_FAIL_CAPTURE_EN
  output logic [CNT_W-1:0] fail_idx,
  output logic [D_W-1:0]   fail_exp,
  output logic [D_W-1:0]   fail_act,
`endif
  output state_t           dbg_state
);

  state_t           state, state_nxt;
  logic             start_acc, last_vec, load_vec, drain_end;
  logic [CNT_W-1:0] vec_idx, vec_idx_nxt, drain_cnt;
  logic [A_W-1:0]   a_gen, b_gen, c_raw, c_gen;
  logic             s_gen;
  logic [D_W-1:0]   exp_cur, exp_chk;
  logic             vld_chk, mismatch;

  assign start_acc   = start && (state == ST_IDLE || state == ST_DONE);
  assign last_vec    = (vec_idx == CNT_W'(NUM_VEC - 1));
  assign drain_end   = (drain_cnt == CNT_W'(DUT_LAT));
  assign load_vec    = start_acc || (state == ST_RUN && !last_vec);
  assign vec_idx_nxt = start_acc ? '0 : vec_idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start)     state_nxt = ST_RUN;
      ST_RUN:           if (last_vec)  state_nxt = ST_DRAIN;
      ST_DRAIN:         if (drain_end) state_nxt = ST_DONE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  hw2_bist_lfsr u_lfsr (
    .CLK   (CLK),
    .reset (reset),
    .seed  (SEED),
    .load  (start_acc),
    .step  (state == ST_RUN && !last_vec),
    .a_nxt (a_gen),
    .b_nxt (b_gen),
    .c_nxt (c_raw),
    .s_nxt (s_gen)
  );

  // First half of the run exercises c=0; the second half never multiplies by zero.
  always_comb begin
    c_gen = c_raw;
    if (vec_idx_nxt < CNT_W'(NUM_VEC / 2)) c_gen = '0;
    else if (c_raw == '0)                  c_gen = A_W'(1);
  end

  // vec_vld: a/b/c/s hold one live vector for exactly the cycle it is high; no back-pressure.
  always_ff @(posedge CLK) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      c         <= '0;
      s         <= 1'b0;
      vec_vld   <= 1'b0;
      vec_idx   <= '0;
      drain_cnt <= '0;
    end else begin
      if (load_vec) begin
        a       <= a_gen;
        b       <= b_gen;
        c       <= c_gen;
        s       <= s_gen;
        vec_idx <= vec_idx_nxt;
      end
      vec_vld   <= load_vec;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  assign exp_cur = hw2_golden(a, b, c, s);

  if (DUT_LAT == 0) begin : g_nodly
    assign exp_chk = exp_cur;
    assign vld_chk = vec_vld;
  end else begin : g_dly
    logic [D_W-1:0] exp_dly [DUT_LAT];
    logic           vld_dly [DUT_LAT];
    always_ff @(posedge CLK) begin
      if (reset) begin
        for (int i = 0; i < DUT_LAT; i++) begin
          exp_dly[i] <= '0;
          vld_dly[i] <= 1'b0;
        end
      end else begin
        exp_dly[0] <= exp_cur;
        vld_dly[0] <= vec_vld;
        for (int i = 1; i < DUT_LAT; i++) begin
          exp_dly[i] <= exp_dly[i-1];
          vld_dly[i] <= vld_dly[i-1];
        end
      end
    end
    assign exp_chk = exp_dly[DUT_LAT-1];
    assign vld_chk = vld_dly[DUT_LAT-1];
  end

  // Case inequality so an unknown d is scored as a failure rather than ignored.
  assign mismatch = vld_chk && (d !== exp_chk);

  always_ff @(posedge CLK) begin
    if (reset || start_acc) begin
      err_cnt <= '0;
    end else if (mismatch && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef HW2_BIST_FAIL_CAPTURE_EN
  logic [CNT_W-1:0] chk_idx;

  always_ff @(posedge CLK) begin
    if (reset || start_acc) begin
      chk_idx  <= '0;
      fail_idx <= '1;
      fail_exp <= '0;
      fail_act <= '0;
    end else if (vld_chk) begin
      chk_idx <= chk_idx + 1'b1;
      if (mismatch && err_cnt == '0) begin
        fail_idx <= chk_idx;
        fail_exp <= exp_chk;
        fail_act <= d;
      end
    end
  end
`endif

  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_cnt == '0);
  assign dbg_state = state;

endmodule
